// File: rtl/tm_cpu_token_gen.sv
// Timing-model side of the FM<->TM token protocol: round-robin TM->FM token issue with per-thread
// quantum budgets and a global barrier. Optional per-thread perf counters under TM_PERF_CNT_EN.

package tm_cpu_token_pkg;
    localparam int NTHREADIDMSB = 2;
    localparam int NTHREADS     = 1 << (NTHREADIDMSB + 1);

    typedef logic [NTHREADIDMSB:0] tid_t;

    typedef enum logic [2:0] {
        tm_dbg_nop          = 3'd0,
        tm_dbg_start        = 3'd1,
        tm_dbg_stop         = 3'd2,
        tm_dbg_select_start = 3'd3,
        tm_dbg_select_stop  = 3'd4
    } tm_dbg_ctrl_type;

    typedef struct packed {
        tid_t            threads_total;
        tid_t            threads_active;
        tm_dbg_ctrl_type tm_dbg_ctrl;
    } dma_tm_ctrl_type;

    typedef struct packed {
        tid_t        tid;
        logic        valid;
        logic        run;
        logic        replay;
        logic        retired;
        logic [31:0] inst;
        logic [31:0] paddr;
        logic [31:0] npc;
    } tm_cpu_ctrl_token_type;

    typedef struct packed {
        logic valid;
        logic run;
        tid_t tid;
        logic running;
    } tm2cpu_token_type;
endpackage

// state    | meaning
// ST_IDLE  | stopped, no tokens emitted, waiting for a start command
// ST_RUN   | issuing run tokens to threads with budget and no token in flight
// ST_SYNC  | quantum barrier: all budgets spent, waiting for in-flight tokens to return
// ST_DRAIN | stop requested: waiting for in-flight tokens, then back to idle
module tm_cpu_token_gen
    import tm_cpu_token_pkg::*;
#(
    parameter int QUANTUM = 64,
    parameter int CNTW    = 16,
    parameter int GCNTW   = 48
) (
    input  logic                  gclk,
    input  logic                  rstn,
    input  dma_tm_ctrl_type       dma_ctrl,
    input  tm_cpu_ctrl_token_type fm_tok,
    output tm2cpu_token_type      tm_tok,
    output logic [GCNTW-1:0]      target_cycle,
    output logic                  busy
`ifdef TM_PERF_CNT_EN
    ,
    input  tid_t                  perf_tid,
    output logic [31:0]           perf_retired,
    output logic [31:0]           perf_replay
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SYNC,
        ST_DRAIN
    } state_t;

    localparam logic [CNTW-1:0]  QLOAD = CNTW'(QUANTUM);
    localparam logic [GCNTW-1:0] GSTEP = GCNTW'(QUANTUM);

    state_t              state;
    tid_t                rr_tid;
    logic [NTHREADS-1:0] en;
    logic [NTHREADS-1:0] out;
    logic [CNTW-1:0]     budget [NTHREADS];

    logic [NTHREADS-1:0] range_mask;
    logic [NTHREADS-1:0] sel_mask;
    logic [NTHREADS-1:0] budget_zero;
    logic [NTHREADS-1:0] issue_mask;
    logic [NTHREADS-1:0] ret_mask;
    logic [NTHREADS-1:0] en_live;
    logic [NTHREADS-1:0] en_nxt;
    logic [NTHREADS-1:0] out_nxt;
    logic                issue;
    logic                ret_ok;
    logic                any_en;
    logic                quantum_done;
    logic                all_idle;
    logic                cmd_start;
    logic                cmd_stop;
    logic                cmd_sel_start;
    logic                cmd_sel_stop;
    tid_t                rr_next;
    logic                unused_fm_bits;

    assign cmd_start     = (dma_ctrl.tm_dbg_ctrl == tm_dbg_start);
    assign cmd_stop      = (dma_ctrl.tm_dbg_ctrl == tm_dbg_stop);
    assign cmd_sel_start = (dma_ctrl.tm_dbg_ctrl == tm_dbg_select_start);
    assign cmd_sel_stop  = (dma_ctrl.tm_dbg_ctrl == tm_dbg_select_stop);

    assign issue  = (state == ST_RUN) && (rr_tid <= dma_ctrl.threads_total) &&
                    en[rr_tid] && (budget[rr_tid] != '0) && !out[rr_tid];
    assign ret_ok = fm_tok.valid && (fm_tok.tid <= dma_ctrl.threads_total);

    always_comb begin
        range_mask  = '0;
        sel_mask    = '0;
        budget_zero = '0;
        issue_mask  = '0;
        ret_mask    = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            range_mask[t]  = (tid_t'(t) <= dma_ctrl.threads_total);
            sel_mask[t]    = (tid_t'(t) == dma_ctrl.threads_active);
            budget_zero[t] = (budget[t] == '0);
            issue_mask[t]  = issue && (tid_t'(t) == rr_tid);
            ret_mask[t]    = ret_ok && (tid_t'(t) == fm_tok.tid);
        end
    end

    assign en_live      = en & range_mask;
    assign any_en       = |en_live;
    assign quantum_done = &(~en_live | budget_zero);
    assign all_idle     = ~|out;
    assign rr_next      = (rr_tid >= dma_ctrl.threads_total) ? '0 : rr_tid + tid_t'(1);

    // An issue and a return for the same tid in one cycle leaves the token in flight.
    assign out_nxt = (out & ~ret_mask) | issue_mask;

    always_comb begin
        en_nxt = en;
        if (state == ST_IDLE) begin
            if (cmd_start) begin
                en_nxt = range_mask;
            end else if (cmd_sel_start) begin
                en_nxt = sel_mask;
            end
        end else if (cmd_sel_start) begin
            en_nxt = en | sel_mask;
        end
        if (cmd_sel_stop) begin
            en_nxt = en_nxt & ~sel_mask;
        end
        if (state == ST_DRAIN && all_idle) begin
            en_nxt = '0;
        end
    end

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            tm_tok       <= '0;
            target_cycle <= '0;
            rr_tid       <= '0;
            en           <= '0;
            out          <= '0;
            for (int t = 0; t < NTHREADS; t++) begin
                budget[t] <= '0;
            end
        end else begin
            en  <= en_nxt;
            out <= out_nxt;
            case (state)
                ST_IDLE: begin
                    tm_tok <= '0;
                    if (cmd_start || cmd_sel_start) begin
                        for (int t = 0; t < NTHREADS; t++) begin
                            budget[t] <= QLOAD;
                        end
                        rr_tid <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    tm_tok.valid   <= 1'b1;
                    tm_tok.run     <= issue;
                    tm_tok.tid     <= rr_tid;
                    tm_tok.running <= 1'b1;
                    rr_tid         <= rr_next;
                    if (issue) begin
                        budget[rr_tid] <= budget[rr_tid] - CNTW'(1);
                    end
                    if (cmd_stop) begin
                        state <= ST_DRAIN;
                    end else if (!any_en) begin
                        state <= ST_IDLE;
                    end else if (quantum_done) begin
                        state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    tm_tok.valid   <= 1'b1;
                    tm_tok.run     <= 1'b0;
                    tm_tok.tid     <= rr_tid;
                    tm_tok.running <= 1'b1;
                    rr_tid         <= rr_next;
                    if (cmd_stop) begin
                        state <= ST_DRAIN;
                    end else if (all_idle) begin
                        for (int t = 0; t < NTHREADS; t++) begin
                            budget[t] <= QLOAD;
                        end
                        target_cycle <= target_cycle + GSTEP;
                        state        <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    tm_tok.valid   <= 1'b1;
                    tm_tok.run     <= 1'b0;
                    tm_tok.tid     <= rr_tid;
                    tm_tok.running <= 1'b1;
                    rr_tid         <= rr_next;
                    if (all_idle) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef TM_PERF_CNT_EN
    logic [31:0] retired_cnt [NTHREADS];
    logic [31:0] replay_cnt  [NTHREADS];

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            for (int t = 0; t < NTHREADS; t++) begin
                retired_cnt[t] <= '0;
                replay_cnt[t]  <= '0;
            end
        end else if (ret_ok && fm_tok.run) begin
            if (fm_tok.replay) begin
                replay_cnt[fm_tok.tid] <= replay_cnt[fm_tok.tid] + 32'd1;
            end else begin
                retired_cnt[fm_tok.tid] <= retired_cnt[fm_tok.tid] + 32'd1;
            end
        end
    end

    assign perf_retired   = retired_cnt[perf_tid];
    assign perf_replay    = replay_cnt[perf_tid];
    assign unused_fm_bits = ^{fm_tok.retired, fm_tok.inst, fm_tok.paddr, fm_tok.npc};
`else
    // Without perf counters only valid/tid of a returning token matter.
    assign unused_fm_bits = ^{fm_tok.run, fm_tok.replay, fm_tok.retired,
                              fm_tok.inst, fm_tok.paddr, fm_tok.npc};
`endif

endmodule

// File: tb/tb_tm_cpu_token_gen.sv
// Directed bench for tm_cpu_token_gen: a QUANTUM=4 instance and a default-QUANTUM instance,
// each with an FM echo model returning run tokens two cycles after issue.

module tb_tm_cpu_token_gen;
    import tm_cpu_token_pkg::*;

    logic                  gclk;
    logic                  rstn;
    dma_tm_ctrl_type       dma_ctrl;
    tm_cpu_ctrl_token_type fm_a, fm_b;
    tm2cpu_token_type      tok_a, tok_b;
    logic [47:0]           target_a, target_b;
    logic                  busy_a, busy_b;
`ifdef TM_PERF_CNT_EN
    tid_t                  perf_tid_a, perf_tid_b;
    logic [31:0]           perf_ret_a, perf_rep_a, perf_ret_b, perf_rep_b;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cnt_a [NTHREADS];
    int cnt_b [NTHREADS];
    bit echo_off    = 1'b0;
    bit replay_mode = 1'b0;
    int tid1_returns = 0;

    tm_cpu_token_gen #(.QUANTUM(4)) dut_a (
        .gclk        (gclk),
        .rstn        (rstn),
        .dma_ctrl    (dma_ctrl),
        .fm_tok      (fm_a),
        .tm_tok      (tok_a),
        .target_cycle(target_a),
        .busy        (busy_a)
`ifdef TM_PERF_CNT_EN
        ,
        .perf_tid    (perf_tid_a),
        .perf_retired(perf_ret_a),
        .perf_replay (perf_rep_a)
`endif
    );

    tm_cpu_token_gen dut_b (
        .gclk        (gclk),
        .rstn        (rstn),
        .dma_ctrl    (dma_ctrl),
        .fm_tok      (fm_b),
        .tm_tok      (tok_b),
        .target_cycle(target_b),
        .busy        (busy_b)
`ifdef TM_PERF_CNT_EN
        ,
        .perf_tid    (perf_tid_b),
        .perf_retired(perf_ret_b),
        .perf_replay (perf_rep_b)
`endif
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    // FM model: echo every run token on the next cycle; optionally replay every 2nd tid-1 insn.
    always @(posedge gclk) begin
        #1;
        if (!echo_off) begin
            fm_a = '0;
            if (tok_a.valid && tok_a.run) begin
                fm_a.valid = 1'b1;
                fm_a.run   = 1'b1;
                fm_a.tid   = tok_a.tid;
                if (replay_mode && tok_a.tid == tid_t'(1)) begin
                    tid1_returns++;
                    fm_a.replay = (tid1_returns % 2 == 0);
                end
            end
        end
        fm_b = '0;
        if (tok_b.valid && tok_b.run) begin
            fm_b.valid = 1'b1;
            fm_b.run   = 1'b1;
            fm_b.tid   = tok_b.tid;
        end
        if (tok_a.valid && tok_a.run) cnt_a[tok_a.tid]++;
        if (tok_b.valid && tok_b.run) cnt_b[tok_b.tid]++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        #2;
    endtask

    task automatic set_ctrl(input tm_dbg_ctrl_type c, input tid_t tt, input tid_t ta);
        dma_ctrl.tm_dbg_ctrl    = c;
        dma_ctrl.threads_total  = tt;
        dma_ctrl.threads_active = ta;
    endtask

    task automatic clear_counts();
        for (int t = 0; t < NTHREADS; t++) begin
            cnt_a[t] = 0;
            cnt_b[t] = 0;
        end
        tid1_returns = 0;
    endtask

    task automatic apply_reset();
        set_ctrl(tm_dbg_nop, 3'd3, 3'd0);
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        clear_counts();
    endtask

    task automatic wait_target(input bit use_b, input logic [47:0] goal, input int limit,
                               input string tag);
        int n = 0;
        while (((use_b ? target_b : target_a) != goal) && n < limit) begin
            tick();
            n++;
        end
        check(tag, 64'(use_b ? target_b : target_a), 64'(goal));
    endtask

    tm2cpu_token_type exp_tok;

    initial begin
        dma_ctrl = '0;
        fm_a     = '0;
        fm_b     = '0;
        rstn     = 1'b0;
`ifdef TM_PERF_CNT_EN
        perf_tid_a = '0;
        perf_tid_b = '0;
`endif
        clear_counts();
        tick();
        tick();
        check("rst_tok",    64'(tok_a), 64'd0);
        check("rst_target", 64'(target_a), 64'd0);
        check("rst_busy",   64'(busy_a), 64'd0);
        rstn = 1'b1;
        tick();

        // Full start, four threads, QUANTUM=4.
        set_ctrl(tm_dbg_start, 3'd3, 3'd0);
        tick();
        set_ctrl(tm_dbg_nop, 3'd3, 3'd0);
        check("start_busy",    64'(busy_a), 64'd1);
        check("start_tok_lat", 64'(tok_a.valid), 64'd0);
        tick();
        exp_tok = '{valid: 1'b1, run: 1'b1, tid: 3'd0, running: 1'b1};
        check("first_tok", 64'(tok_a), 64'(exp_tok));
        wait_target(1'b0, 48'd4, 200, "q1_target");
        for (int t = 0; t < 4; t++) check($sformatf("q1_runs_tid%0d", t), 64'(cnt_a[t]), 64'd4);
        check("q1_runs_hi_tids", 64'(cnt_a[4] + cnt_a[5] + cnt_a[6] + cnt_a[7]), 64'd0);
        wait_target(1'b0, 48'd8, 200, "q2_target");
        check("q2_runs_tid0", 64'(cnt_a[0]), 64'd8);
        check("q2_runs_tid3", 64'(cnt_a[3]), 64'd8);

        // Reset in the middle of RUN.
        check("pre_rst_busy", 64'(busy_a), 64'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_tok",    64'(tok_a), 64'd0);
        check("mid_rst_target", 64'(target_a), 64'd0);
        check("mid_rst_busy",   64'(busy_a), 64'd0);
        tick();
        rstn = 1'b1;
        tick();
        check("post_rst_busy", 64'(busy_a), 64'd0);

        // Replay every 2nd tid-1 instruction: budget is not refunded.
        apply_reset();
        replay_mode = 1'b1;
        set_ctrl(tm_dbg_start, 3'd3, 3'd0);
        tick();
        set_ctrl(tm_dbg_nop, 3'd3, 3'd0);
        wait_target(1'b0, 48'd4, 200, "rp_target");
        check("rp_runs_tid1", 64'(cnt_a[1]), 64'd4);
        check("rp_runs_tid2", 64'(cnt_a[2]), 64'd4);
`ifdef TM_PERF_CNT_EN
        perf_tid_a = 3'd1;
        #1;
        check("rp_perf_replay1",  64'(perf_rep_a), 64'd2);
        check("rp_perf_retired1", 64'(perf_ret_a), 64'd2);
`endif
        replay_mode = 1'b0;

        // Stop with two tokens outstanding; FM returns them by hand.
        apply_reset();
        echo_off = 1'b1;
        fm_a     = '0;
        set_ctrl(tm_dbg_start, 3'd1, 3'd0);
        tick();
        set_ctrl(tm_dbg_nop, 3'd1, 3'd0);
        tick();
        check("stop_issue0", 64'({tok_a.run, tok_a.tid}), 64'({1'b1, 3'd0}));
        tick();
        check("stop_issue1", 64'({tok_a.run, tok_a.tid}), 64'({1'b1, 3'd1}));
        set_ctrl(tm_dbg_stop, 3'd1, 3'd0);
        tick();
        set_ctrl(tm_dbg_nop, 3'd1, 3'd0);
        tick();
        check("drain_tok", 64'({tok_a.valid, tok_a.run, tok_a.running}), 64'({1'b1, 1'b0, 1'b1}));
        fm_a.valid = 1'b1;
        fm_a.run   = 1'b1;
        fm_a.tid   = 3'd0;
        tick();
        check("drain_busy_a", 64'(busy_a), 64'd1);
        fm_a.tid = 3'd1;
        tick();
        fm_a = '0;
        check("drain_run", 64'(tok_a.run), 64'd0);
        check("drain_busy_b", 64'(busy_a), 64'd1);
        tick();
        check("drain_idle", 64'(busy_a), 64'd0);
        check("drain_target", 64'(target_a), 64'd0);
        tick();
        check("idle_tok_valid", 64'(tok_a.valid), 64'd0);
        echo_off = 1'b0;

        // select_start tid 2 only, default quantum instance.
        apply_reset();
        set_ctrl(tm_dbg_select_start, 3'd3, 3'd2);
        tick();
        set_ctrl(tm_dbg_nop, 3'd3, 3'd2);
        wait_target(1'b1, 48'd64, 1200, "sel_target64");
        check("sel_runs_tid2", 64'(cnt_b[2]), 64'd64);
        check("sel_runs_other", 64'(cnt_b[0] + cnt_b[1] + cnt_b[3]), 64'd0);

        // select_stop tid 0 after its first issue; barrier completes without it.
        apply_reset();
        set_ctrl(tm_dbg_start, 3'd3, 3'd0);
        tick();
        set_ctrl(tm_dbg_nop, 3'd3, 3'd0);
        tick();
        tick();
        set_ctrl(tm_dbg_select_stop, 3'd3, 3'd0);
        tick();
        set_ctrl(tm_dbg_nop, 3'd3, 3'd0);
        wait_target(1'b0, 48'd4, 200, "ss_target4");
        check("ss_runs_tid0", 64'(cnt_a[0]), 64'd1);
        check("ss_runs_tid1", 64'(cnt_a[1]), 64'd4);
        wait_target(1'b0, 48'd8, 200, "ss_target8");
        check("ss_runs_tid0_q2", 64'(cnt_a[0]), 64'd1);
        check("ss_runs_tid3_q2", 64'(cnt_a[3]), 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
